// File: rtl/data_mem_write_buffer_if.sv
// Block-transfer bus between a requester and a responder.
// Used on both the cache side and the memory side of the buffer.
interface data_mem_write_buffer_if;
  logic         read;
  logic         write;
  logic [27:0]  address;
  logic [127:0] writedata;
  logic [127:0] readdata;
  logic         busywait;

  modport master (
    output read,
    output write,
    output address,
    output writedata,
    input  readdata,
    input  busywait
  );

  modport slave (
    input  read,
    input  write,
    input  address,
    input  writedata,
    output readdata,
    output busywait
  );
endinterface

// File: rtl/data_mem_write_buffer.sv
// Posted-write buffer between the data cache and data memory.
// Evictions are queued and drained in order; reads forward from the queue.
module data_mem_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                    CLK,
  input  logic                    RESET,
  data_mem_write_buffer_if.slave  c,
  data_mem_write_buffer_if.master m
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    MREAD,
    RDONE
  } state_t;

  state_t         state_q;
  state_t         state_d;

  logic [DEPTH-1:0] vld_q;
  logic [27:0]      addr_q [DEPTH];
  logic [127:0]     data_q [DEPTH];
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [PW:0]      count_q;

  logic [127:0]   rd_q;
  logic [127:0]   hold_q;

  logic           hit;
  logic [127:0]   hit_data;
  logic           full;
  logic           rd_miss;
  logic           enq;
  logic           deq;
  logic           mem_done;
  logic           rd_cap;

  // Youngest valid entry matching the cache address; later ages override.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[head_q + PW'(i)] &&
          addr_q[head_q + PW'(i)] == c.address) begin
        hit      = 1'b1;
        hit_data = data_q[head_q + PW'(i)];
      end
    end
  end

  assign full     = (count_q == (PW+1)'(DEPTH));
  assign rd_miss  = c.read && !hit;
  assign enq      = c.write && !c.read && !full;
  assign mem_done = (state_q == DRAIN || state_q == MREAD)
                    && !m.busywait;
  assign deq      = (state_q == DRAIN) && mem_done;
  assign rd_cap   = (state_q == MREAD) && mem_done;

  // State register; reset abandons any in-flight memory operation.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and memory-side request; reads win over draining.
  always_comb begin
    state_d     = state_q;
    m.read      = 1'b0;
    m.write     = 1'b0;
    m.address   = '0;
    m.writedata = '0;
    unique case (state_q)
      IDLE: begin
        if (rd_miss) begin
          state_d = MREAD;
        end else if (count_q != '0) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        m.write     = 1'b1;
        m.address   = addr_q[head_q];
        m.writedata = data_q[head_q];
        if (mem_done) begin
          state_d = IDLE;
        end
      end
      MREAD: begin
        m.read    = 1'b1;
        m.address = c.address;
        if (mem_done) begin
          state_d = RDONE;
        end
      end
      RDONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Cache-side stall and returned block; data holds when nothing is served.
  always_comb begin
    c.busywait = 1'b0;
    c.readdata = hold_q;
    if (c.read) begin
      if (hit) begin
        c.readdata = hit_data;
      end else if (state_q == RDONE) begin
        c.readdata = rd_q;
      end else begin
        c.busywait = 1'b1;
      end
    end else if (c.write) begin
      c.busywait = full;
    end
  end

  // Queue bookkeeping: valid bits, pointers and occupancy.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (deq) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + PW'(1);
      end
      if (enq) begin
        vld_q[tail_q] <= 1'b1;
        tail_q        <= tail_q + PW'(1);
      end
      unique case ({enq, deq})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry payload; only meaningful where the valid bit is set.
  always_ff @(posedge CLK) begin
    if (enq) begin
      addr_q[tail_q] <= c.address;
      data_q[tail_q] <= c.writedata;
    end
  end

  // Read register for misses and the held cache-side data.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rd_q   <= '0;
      hold_q <= '0;
    end else begin
      if (rd_cap) begin
        rd_q <= m.readdata;
      end
      hold_q <= c.readdata;
    end
  end

endmodule
